// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, ALU function
// codes, the "no register" ID, bubble field values and the condition helper.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Status codes
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  // ALU function codes
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  // Register ID meaning "no destination / no source"
  localparam logic [3:0] REG_NONE = 4'hF;

  // Field values loaded by a pipeline bubble
  localparam logic [3:0] BUBBLE_ICODE = I_NOP;
  localparam logic [3:0] BUBBLE_IFUN  = 4'h0;
  localparam logic [2:0] BUBBLE_STAT  = S_AOK;

  // Condition codes
  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  // Branch / conditional-move condition from a function code and flags.
  function automatic logic cond_eval(input logic [3:0] ifun, input cc_t cc);
    logic lt;
    logic res;
    lt  = cc.sf ^ cc.of;
    res = 1'b0;
    case (ifun)
      4'd0:    res = 1'b1;
      4'd1:    res = lt | cc.zf;
      4'd2:    res = lt;
      4'd3:    res = cc.zf;
      4'd4:    res = ~cc.zf;
      4'd5:    res = ~lt;
      4'd6:    res = ~lt & ~cc.zf;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode-to-execute inputs, stage control, hazard/forwarding outputs and the
// M pipeline register outputs of the execute stage.
interface execute_stage_if #(parameter int W = 64);

  logic [2:0]   d_stat;
  logic [3:0]   d_icode;
  logic [3:0]   d_ifun;
  logic [W-1:0] d_valA;
  logic [W-1:0] d_valB;
  logic [W-1:0] d_valC;
  logic [3:0]   d_dstE;
  logic [3:0]   d_dstM;
  logic [3:0]   d_srcA;
  logic [3:0]   d_srcB;

  logic         E_stall;
  logic         E_bubble;
  logic         M_bubble;
  logic         set_cc_block;

  logic [3:0]   E_srcA;
  logic [3:0]   E_srcB;
  logic [3:0]   E_dstM;
  logic [3:0]   E_icode;
  logic [3:0]   e_dstE;
  logic [W-1:0] e_valE;

  logic [2:0]   M_stat;
  logic [3:0]   M_icode;
  logic         M_Cnd;
  logic [W-1:0] M_valE;
  logic [W-1:0] M_valA;
  logic [3:0]   M_dstE;
  logic [3:0]   M_dstM;

  // Decode / pipeline control side
  modport master (
    output d_stat, d_icode, d_ifun, d_valA, d_valB, d_valC,
           d_dstE, d_dstM, d_srcA, d_srcB,
           E_stall, E_bubble, M_bubble, set_cc_block,
    input  E_srcA, E_srcB, E_dstM, E_icode, e_dstE, e_valE,
           M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
  );

  // Execute stage side
  modport slave (
    input  d_stat, d_icode, d_ifun, d_valA, d_valB, d_valC,
           d_dstE, d_dstM, d_srcA, d_srcB,
           E_stall, E_bubble, M_bubble, set_cc_block,
    output E_srcA, E_srcB, E_dstM, E_icode, e_dstE, e_valE,
           M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
  );

endinterface

// File: rtl/execute_stage_alu.sv
// Y86-64 ALU: res = x op y for add, sub, and, xor. carry_bit is the
// unsigned carry/borrow out of add/sub.
module ALU
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [1:0]   control,
  output logic [W-1:0] res,
  output logic         carry_bit
);

  // Combinational operation select
  always_comb begin
    res       = '0;
    carry_bit = 1'b0;
    case (control)
      ALU_ADD: {carry_bit, res} = {1'b0, x} + {1'b0, y};
      ALU_SUB: {carry_bit, res} = {1'b0, x} - {1'b0, y};
      ALU_AND: res = x & y;
      default: res = x ^ y;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage of the pipelined Y86-64 core: E pipeline register, ALU
// operand/function selection, condition codes, branch/cmov condition and the
// M pipeline register.
module execute_stage
  import y86_pkg::*;
#(
  parameter int         W     = 64,
  parameter logic [3:0] RNONE = REG_NONE
) (
  input logic             clk,
  input logic             rst_n,
  execute_stage_if.slave  bus
);

  localparam logic [W-1:0] EIGHT = W'(8);

  // E pipeline register
  logic [2:0]   E_stat;
  logic [3:0]   E_icode;
  logic [3:0]   E_ifun;
  logic [W-1:0] E_valA;
  logic [W-1:0] E_valB;
  logic [W-1:0] E_valC;
  logic [3:0]   E_dstE;
  logic [3:0]   E_dstM;
  logic [3:0]   E_srcA;
  logic [3:0]   E_srcB;

  // Execute datapath
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [1:0]   alu_fun;
  logic [W-1:0] e_valE;
  logic         e_cnd;
  logic [3:0]   e_dstE;
  cc_t          cc_reg;
  cc_t          cc_next;

  // M pipeline register
  logic [2:0]   M_stat;
  logic [3:0]   M_icode;
  logic         M_Cnd;
  logic [W-1:0] M_valE;
  logic [W-1:0] M_valA;
  logic [3:0]   M_dstE;
  logic [3:0]   M_dstM;

  // E register: bubble beats stall, stall holds, otherwise load from decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      E_stat  <= BUBBLE_STAT;
      E_icode <= BUBBLE_ICODE;
      E_ifun  <= BUBBLE_IFUN;
      E_valA  <= '0;
      E_valB  <= '0;
      E_valC  <= '0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else if (bus.E_bubble) begin
      E_stat  <= BUBBLE_STAT;
      E_icode <= BUBBLE_ICODE;
      E_ifun  <= BUBBLE_IFUN;
      E_valA  <= '0;
      E_valB  <= '0;
      E_valC  <= '0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else if (!bus.E_stall) begin
      E_stat  <= bus.d_stat;
      E_icode <= bus.d_icode;
      E_ifun  <= bus.d_ifun;
      E_valA  <= bus.d_valA;
      E_valB  <= bus.d_valB;
      E_valC  <= bus.d_valC;
      E_dstE  <= bus.d_dstE;
      E_dstM  <= bus.d_dstM;
      E_srcA  <= bus.d_srcA;
      E_srcB  <= bus.d_srcB;
    end
  end

  // ALU operand and function selection by instruction class
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_fun = ALU_ADD;
    case (E_icode)
      I_OPQ, I_RRMOVQ:              alu_a = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
      I_CALL, I_PUSHQ:              alu_a = -EIGHT;
      I_RET, I_POPQ:                alu_a = EIGHT;
      default:                      alu_a = '0;
    endcase
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
      I_PUSHQ, I_RET, I_POPQ:       alu_b = E_valB;
      default:                      alu_b = '0;
    endcase
    if (E_icode == I_OPQ) begin
      alu_fun = E_ifun[1:0];
    end
  end

  // Carry out is not architecturally visible in Y86-64
  ALU #(.W(W)) u_alu (
    .x         (alu_b),
    .y         (alu_a),
    .control   (alu_fun),
    .res       (e_valE),
    .carry_bit ()
  );

  // Flags the current ALU result would write; overflow is signed only
  always_comb begin
    cc_next.zf = (e_valE == '0);
    cc_next.sf = e_valE[W-1];
    cc_next.of = 1'b0;
    case (alu_fun)
      ALU_ADD: cc_next.of = (alu_a[W-1] == alu_b[W-1]) && (e_valE[W-1] != alu_b[W-1]);
      ALU_SUB: cc_next.of = (alu_b[W-1] != alu_a[W-1]) && (e_valE[W-1] != alu_b[W-1]);
      default: cc_next.of = 1'b0;
    endcase
  end

  // Condition codes: only OPQ writes, and not while a later stage is faulting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_reg <= CC_RESET;
    end else if ((E_icode == I_OPQ) && !bus.set_cc_block) begin
      cc_reg <= cc_next;
    end
  end

  // Condition uses the flags already in the register, and only gates jumps and cmovs
  always_comb begin
    e_cnd  = 1'b1;
    e_dstE = E_dstE;
    if ((E_icode == I_JXX) || (E_icode == I_RRMOVQ)) begin
      e_cnd = cond_eval(E_ifun, cc_reg);
    end
    if ((E_icode == I_RRMOVQ) && !e_cnd) begin
      e_dstE = RNONE;
    end
  end

  // M register: no stall, bubble clears the condition flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_stat  <= BUBBLE_STAT;
      M_icode <= BUBBLE_ICODE;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (bus.M_bubble) begin
      M_stat  <= BUBBLE_STAT;
      M_icode <= BUBBLE_ICODE;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else begin
      M_stat  <= E_stat;
      M_icode <= E_icode;
      M_Cnd   <= e_cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

  assign bus.E_srcA  = E_srcA;
  assign bus.E_srcB  = E_srcB;
  assign bus.E_dstM  = E_dstM;
  assign bus.E_icode = E_icode;
  assign bus.e_dstE  = e_dstE;
  assign bus.e_valE  = e_valE;
  assign bus.M_stat  = M_stat;
  assign bus.M_icode = M_icode;
  assign bus.M_Cnd   = M_Cnd;
  assign bus.M_valE  = M_valE;
  assign bus.M_valA  = M_valA;
  assign bus.M_dstE  = M_dstE;
  assign bus.M_dstM  = M_dstM;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed vector table, hand-written control
// sequences and randomized traffic against an instruction-level model.
module tb_execute_stage;
  import y86_pkg::*;

  localparam int W = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  execute_stage_if #(.W(W)) bus();

  execute_stage #(.W(W), .RNONE(4'hF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
  } instr_t;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } mres_t;

  typedef struct packed {
    instr_t      ins;
    logic [63:0] exp_valE;
    logic        exp_cnd;
    logic [3:0]  exp_dstE;
  } vec_t;

  vec_t vec[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic [3:0] icode, input logic [3:0] ifun,
                                input logic [63:0] valA, input logic [63:0] valB,
                                input logic [63:0] valC, input logic [3:0] dstE);
    instr_t i;
    i.stat  = 3'd1;
    i.icode = icode;
    i.ifun  = ifun;
    i.valA  = valA;
    i.valB  = valB;
    i.valC  = valC;
    i.dstE  = dstE;
    i.dstM  = 4'hF;
    i.srcA  = 4'h1;
    i.srcB  = 4'h2;
    return i;
  endfunction

  function automatic instr_t bubble_i();
    instr_t i;
    i = mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
    i.srcA = 4'hF;
    i.srcB = 4'hF;
    return i;
  endfunction

  function automatic void add_vec(input instr_t ins, input logic [63:0] v,
                                  input logic c, input logic [3:0] d);
    vec_t t;
    t.ins = ins;
    t.exp_valE = v;
    t.exp_cnd = c;
    t.exp_dstE = d;
    vec.push_back(t);
  endfunction

  // Instruction-level reference: what the instruction computes, its flags
  // (via exact 65-bit signed arithmetic) and whether its condition holds.
  function automatic mres_t exec(input instr_t e, input cc_t cc, output cc_t flags);
    mres_t m;
    logic [63:0] r;
    logic signed [64:0] wide;
    logic cnd;
    r = 64'd0;
    wide = 65'sd0;
    flags = '0;
    case (e.icode)
      4'h6: begin
        case (e.ifun[1:0])
          2'd0: begin
            r = e.valB + e.valA;
            wide = $signed({e.valB[63], e.valB}) + $signed({e.valA[63], e.valA});
          end
          2'd1: begin
            r = e.valB - e.valA;
            wide = $signed({e.valB[63], e.valB}) - $signed({e.valA[63], e.valA});
          end
          2'd2: begin
            r = e.valB & e.valA;
            wide = $signed({r[63], r});
          end
          default: begin
            r = e.valB ^ e.valA;
            wide = $signed({r[63], r});
          end
        endcase
        flags.zf = (r == 64'd0);
        flags.sf = r[63];
        flags.of = (wide != $signed({r[63], r}));
      end
      4'h2:       r = e.valA;
      4'h3:       r = e.valC;
      4'h4, 4'h5: r = e.valB + e.valC;
      4'h8, 4'hA: r = e.valB - 64'd8;
      4'h9, 4'hB: r = e.valB + 64'd8;
      default:    r = 64'd0;
    endcase
    cnd = 1'b1;
    if (e.icode == 4'h7 || e.icode == 4'h2) begin
      case (e.ifun)
        4'd0:    cnd = 1'b1;
        4'd1:    cnd = (cc.sf ^ cc.of) | cc.zf;
        4'd2:    cnd = cc.sf ^ cc.of;
        4'd3:    cnd = cc.zf;
        4'd4:    cnd = !cc.zf;
        4'd5:    cnd = !(cc.sf ^ cc.of);
        4'd6:    cnd = !(cc.sf ^ cc.of) && !cc.zf;
        default: cnd = 1'b0;
      endcase
    end
    m.stat  = e.stat;
    m.icode = e.icode;
    m.cnd   = cnd;
    m.valE  = r;
    m.valA  = e.valA;
    m.dstE  = (e.icode == 4'h2 && !cnd) ? 4'hF : e.dstE;
    m.dstM  = e.dstM;
    return m;
  endfunction

  task automatic drive(input instr_t i, input logic stall, input logic ebub,
                       input logic mbub, input logic block);
    bus.d_stat       = i.stat;
    bus.d_icode      = i.icode;
    bus.d_ifun       = i.ifun;
    bus.d_valA       = i.valA;
    bus.d_valB       = i.valB;
    bus.d_valC       = i.valC;
    bus.d_dstE       = i.dstE;
    bus.d_dstM       = i.dstM;
    bus.d_srcA       = i.srcA;
    bus.d_srcB       = i.srcB;
    bus.E_stall      = stall;
    bus.E_bubble     = ebub;
    bus.M_bubble     = mbub;
    bus.set_cc_block = block;
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge
  task automatic step(input instr_t i, input logic stall, input logic ebub,
                      input logic mbub, input logic block);
    @(negedge clk);
    drive(i, stall, ebub, mbub, block);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand64();
    logic [63:0] v;
    case ($urandom_range(0, 9))
      0: v = 64'd0;
      1: v = 64'h7FFF_FFFF_FFFF_FFFF;
      2: v = 64'h8000_0000_0000_0000;
      3: v = 64'hFFFF_FFFF_FFFF_FFFF;
      4: v = 64'd8;
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  instr_t nop_i;
  instr_t g;
  instr_t e_m;
  instr_t d_in;
  mres_t  m_exp;
  mres_t  e_exp;
  cc_t    cc_m;
  cc_t    fl;
  cc_t    fl_unused;
  logic   r_stall, r_ebub, r_mbub, r_block;
  logic [4:0] pick;

  initial begin
    nop_i = mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);

    // Directed vectors, applied back to back; CC effects chain through them
    add_vec(mk(4'h7, 4'h3, 64'd0, 64'd0, 64'h400, 4'hF), 64'd0, 1'b1, 4'hF);                 // je after reset (ZF=1)
    add_vec(mk(4'h7, 4'h2, 64'd0, 64'd0, 64'h400, 4'hF), 64'd0, 1'b0, 4'hF);                 // jl after reset
    add_vec(mk(4'h6, 4'h1, 64'd10, 64'd20, 64'd0, 4'h2), 64'd10, 1'b1, 4'h2);                // sub -> CC 000
    add_vec(mk(4'h7, 4'h3, 64'd0, 64'd0, 64'h400, 4'hF), 64'd0, 1'b0, 4'hF);                 // je
    add_vec(mk(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2),
            64'h8000_0000_0000_0000, 1'b1, 4'h2);                                            // add overflow -> 011
    add_vec(mk(4'h7, 4'h2, 64'd0, 64'd0, 64'h400, 4'hF), 64'd0, 1'b0, 4'hF);                 // jl
    add_vec(mk(4'h7, 4'h1, 64'd0, 64'd0, 64'h400, 4'hF), 64'd0, 1'b0, 4'hF);                 // jle
    add_vec(mk(4'h2, 4'h3, 64'h55, 64'h99, 64'd0, 4'h3), 64'h55, 1'b0, 4'hF);                // cmove, ZF=0
    add_vec(mk(4'h6, 4'h3, 64'd5, 64'd5, 64'd0, 4'h6), 64'd0, 1'b1, 4'h6);                   // xor -> 100
    add_vec(mk(4'h2, 4'h3, 64'h55, 64'h99, 64'd0, 4'h3), 64'h55, 1'b1, 4'h3);                // cmove, ZF=1
    add_vec(mk(4'hA, 4'h0, 64'h11, 64'h100, 64'd0, 4'h4), 64'hF8, 1'b1, 4'h4);               // pushq
    add_vec(mk(4'h8, 4'h0, 64'h11, 64'h100, 64'h800, 4'h4), 64'hF8, 1'b1, 4'h4);             // call
    add_vec(mk(4'hB, 4'h0, 64'h11, 64'hF8, 64'd0, 4'h4), 64'h100, 1'b1, 4'h4);               // popq
    add_vec(mk(4'h9, 4'h0, 64'h11, 64'h200, 64'd0, 4'h4), 64'h208, 1'b1, 4'h4);              // ret
    add_vec(mk(4'h3, 4'h0, 64'h11, 64'hDEAD, 64'h1234, 4'h5), 64'h1234, 1'b1, 4'h5);         // irmovq
    add_vec(mk(4'h5, 4'h0, 64'h11, 64'h40, 64'd8, 4'hF), 64'h48, 1'b1, 4'hF);                // mrmovq
    add_vec(mk(4'h4, 4'h0, 64'h11, 64'h1000, 64'h10, 4'hF), 64'h1010, 1'b1, 4'hF);           // rmmovq
    add_vec(mk(4'h6, 4'h2, 64'hF0, 64'h3C, 64'd0, 4'h7), 64'h30, 1'b1, 4'h7);                // and -> 000
    add_vec(mk(4'h7, 4'h0, 64'd0, 64'd0, 64'h400, 4'hF), 64'd0, 1'b1, 4'hF);                 // jmp
    add_vec(mk(4'h7, 4'h4, 64'd0, 64'd0, 64'h400, 4'hF), 64'd0, 1'b1, 4'hF);                 // jne
    add_vec(mk(4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 4'h8), 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 4'h8); // sub -> 010
    add_vec(mk(4'h7, 4'h2, 64'd0, 64'd0, 64'h400, 4'hF), 64'd0, 1'b1, 4'hF);                 // jl
    add_vec(mk(4'h7, 4'h6, 64'd0, 64'd0, 64'h400, 4'hF), 64'd0, 1'b0, 4'hF);                 // jg
    add_vec(mk(4'h7, 4'h9, 64'd0, 64'd0, 64'h400, 4'hF), 64'd0, 1'b0, 4'hF);                 // undefined cond
    add_vec(mk(4'h2, 4'h0, 64'h77, 64'd0, 64'd0, 4'h7), 64'h77, 1'b1, 4'h7);                 // rrmovq
    add_vec(mk(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 4'h9),
            64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 4'h9);                                            // sub overflow -> 001
    add_vec(mk(4'h7, 4'h2, 64'd0, 64'd0, 64'h400, 4'hF), 64'd0, 1'b1, 4'hF);                 // jl
    add_vec(mk(4'h7, 4'h5, 64'd0, 64'd0, 64'h400, 4'hF), 64'd0, 1'b0, 4'hF);                 // jge
    add_vec(mk(4'h2, 4'h1, 64'h9, 64'd0, 64'd0, 4'h8), 64'h9, 1'b1, 4'h8);                   // cmovle
    add_vec(mk(4'h0, 4'h0, 64'd123, 64'd456, 64'd789, 4'hF), 64'd0, 1'b1, 4'hF);             // halt
    add_vec(mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF), 64'd0, 1'b1, 4'hF);                   // nop

    // Reset with garbage on the decode inputs
    g = mk(4'h6, 4'h1, 64'hDEAD_BEEF, 64'hCAFE, 64'h1234, 4'h3);
    g.stat = 3'd4;
    drive(g, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset with garbage inputs");
    check("reset M_icode", bus.M_icode, 4'h1);
    check("reset M_stat", bus.M_stat, 3'd1);
    check("reset M_dstE", bus.M_dstE, 4'hF);
    check("reset M_dstM", bus.M_dstM, 4'hF);
    check("reset M_Cnd", bus.M_Cnd, 1'b0);
    check("reset M_valE", bus.M_valE, 64'd0);
    check("reset E_icode", bus.E_icode, 4'h1);
    check("reset E_srcA", bus.E_srcA, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;
    drive(nop_i, 1'b0, 1'b1, 1'b0, 1'b0);

    // Vector table; entry i is in E after iteration i and in M after i+1
    for (int i = 0; i <= vec.size(); i++) begin
      @(negedge clk);
      if (i < vec.size()) drive(vec[i].ins, 1'b0, 1'b0, 1'b0, 1'b0);
      else                drive(nop_i, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      if (i < vec.size()) begin
        $display("[TB] vec %0d icode=%0h ifun=%0h e_valE=%0h e_dstE=%0h",
                 i, vec[i].ins.icode, vec[i].ins.ifun, bus.e_valE, bus.e_dstE);
        check($sformatf("vec%0d e_valE", i), bus.e_valE, vec[i].exp_valE);
        check($sformatf("vec%0d e_dstE", i), bus.e_dstE, vec[i].exp_dstE);
      end
      if (i > 0) begin
        check($sformatf("vec%0d M_valE", i - 1), bus.M_valE, vec[i-1].exp_valE);
        check($sformatf("vec%0d M_Cnd", i - 1), bus.M_Cnd, vec[i-1].exp_cnd);
        check($sformatf("vec%0d M_dstE", i - 1), bus.M_dstE, vec[i-1].exp_dstE);
        check($sformatf("vec%0d M_icode", i - 1), bus.M_icode, vec[i-1].ins.icode);
      end
    end

    // E_stall holds the E register for two cycles, then resumes
    $display("[TB] seq stall");
    step(mk(4'h6, 4'h0, 64'd2, 64'd3, 64'd0, 4'h1), 1'b0, 1'b0, 1'b0, 1'b0);
    check("stall0 E_icode", bus.E_icode, 4'h6);
    check("stall0 e_valE", bus.e_valE, 64'd5);
    for (int k = 1; k <= 2; k++) begin
      step(mk(4'h3, 4'h0, 64'd0, 64'd0, 64'h99, 4'h2), 1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("stall%0d E_icode", k), bus.E_icode, 4'h6);
      check($sformatf("stall%0d e_valE", k), bus.e_valE, 64'd5);
      check($sformatf("stall%0d M_valE", k), bus.M_valE, 64'd5);
    end
    step(mk(4'h3, 4'h0, 64'd0, 64'd0, 64'h99, 4'h2), 1'b0, 1'b0, 1'b0, 1'b0);
    check("resume E_icode", bus.E_icode, 4'h3);
    check("resume e_valE", bus.e_valE, 64'h99);
    step(nop_i, 1'b0, 1'b0, 1'b0, 1'b0);
    check("resume M_icode", bus.M_icode, 4'h3);
    check("resume M_dstE", bus.M_dstE, 4'h2);

    // Bubble together with stall loads a NOP
    $display("[TB] seq bubble+stall");
    step(mk(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h5), 1'b1, 1'b1, 1'b0, 1'b0);
    check("bub E_icode", bus.E_icode, 4'h1);
    check("bub E_srcA", bus.E_srcA, 4'hF);
    check("bub e_dstE", bus.e_dstE, 4'hF);
    check("bub e_valE", bus.e_valE, 64'd0);
    step(nop_i, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bub M_icode", bus.M_icode, 4'h1);

    // set_cc_block suppresses the xor's flag update; then the unblocked case
    $display("[TB] seq cc block");
    step(mk(4'h6, 4'h1, 64'd10, 64'd20, 64'd0, 4'h2), 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(4'h6, 4'h3, 64'd5, 64'd5, 64'd0, 4'h3), 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(4'h7, 4'h3, 64'd0, 64'd0, 64'h40, 4'hF), 1'b0, 1'b0, 1'b0, 1'b1);
    step(nop_i, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ccblock je M_Cnd", bus.M_Cnd, 1'b0);
    step(mk(4'h6, 4'h3, 64'd5, 64'd5, 64'd0, 4'h3), 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(4'h7, 4'h3, 64'd0, 64'd0, 64'h40, 4'hF), 1'b0, 1'b0, 1'b0, 1'b0);
    step(nop_i, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ccopen je M_Cnd", bus.M_Cnd, 1'b1);

    // M_bubble replaces the M register load
    $display("[TB] seq M bubble");
    step(mk(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h4), 1'b0, 1'b0, 1'b0, 1'b0);
    step(nop_i, 1'b0, 1'b0, 1'b1, 1'b0);
    check("mbub M_icode", bus.M_icode, 4'h1);
    check("mbub M_Cnd", bus.M_Cnd, 1'b0);
    check("mbub M_valE", bus.M_valE, 64'd0);
    check("mbub M_dstE", bus.M_dstE, 4'hF);
    step(nop_i, 1'b0, 1'b0, 1'b0, 1'b0);
    check("after mbub M_Cnd", bus.M_Cnd, 1'b1);

    // Asynchronous reset mid-cycle, then CC back to {ZF=1,SF=0,OF=0}
    $display("[TB] seq async reset");
    step(mk(4'h6, 4'h1, 64'd10, 64'd20, 64'd0, 4'h2), 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(4'h6, 4'h1, 64'd10, 64'd20, 64'd0, 4'h2), 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre-rst M_valE", bus.M_valE, 64'd10);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst M_icode", bus.M_icode, 4'h1);
    check("arst M_valE", bus.M_valE, 64'd0);
    check("arst M_dstE", bus.M_dstE, 4'hF);
    check("arst E_icode", bus.E_icode, 4'h1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(nop_i, 1'b0, 1'b1, 1'b0, 1'b0);
    step(mk(4'h7, 4'h3, 64'd0, 64'd0, 64'h40, 4'hF), 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(4'h7, 4'h2, 64'd0, 64'd0, 64'h40, 4'hF), 1'b0, 1'b0, 1'b0, 1'b0);
    check("arst je M_Cnd", bus.M_Cnd, 1'b1);
    step(nop_i, 1'b0, 1'b0, 1'b0, 1'b0);
    check("arst jl M_Cnd", bus.M_Cnd, 1'b0);

    // Randomized traffic against the instruction-level model
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    e_m  = bubble_i();
    cc_m = CC_RESET;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      rst_n = 1'b1;
      pick = 5'($urandom_range(0, 19));
      d_in.icode = (pick < 5'd16) ? pick[3:0] : ((pick < 5'd18) ? 4'h6 : 4'h7);
      d_in.ifun  = 4'($urandom_range(0, 15));
      d_in.stat  = 3'($urandom_range(1, 4));
      d_in.valA  = rand64();
      d_in.valB  = rand64();
      d_in.valC  = rand64();
      d_in.dstE  = 4'($urandom_range(0, 15));
      d_in.dstM  = 4'($urandom_range(0, 15));
      d_in.srcA  = 4'($urandom_range(0, 15));
      d_in.srcB  = 4'($urandom_range(0, 15));
      r_stall = ($urandom_range(0, 7) == 0);
      r_ebub  = ($urandom_range(0, 9) == 0);
      r_mbub  = ($urandom_range(0, 9) == 0);
      r_block = ($urandom_range(0, 5) == 0);
      drive(d_in, r_stall, r_ebub, r_mbub, r_block);
      @(posedge clk);
      // Model update for this edge
      m_exp = exec(e_m, cc_m, fl);
      if (r_mbub) begin
        m_exp = '{stat: 3'd1, icode: 4'h1, cnd: 1'b0, valE: 64'd0, valA: 64'd0,
                  dstE: 4'hF, dstM: 4'hF};
      end
      if (e_m.icode == 4'h6 && !r_block) cc_m = fl;
      if (r_ebub)        e_m = bubble_i();
      else if (!r_stall) e_m = d_in;
      e_exp = exec(e_m, cc_m, fl_unused);
      #1;
      $display("[TB] rnd %0d d_icode=%0h ifun=%0h stall=%0b ebub=%0b mbub=%0b blk=%0b M_icode=%0h M_valE=%0h",
               n, d_in.icode, d_in.ifun, r_stall, r_ebub, r_mbub, r_block, bus.M_icode, bus.M_valE);
      check($sformatf("rnd%0d M_stat", n), bus.M_stat, m_exp.stat);
      check($sformatf("rnd%0d M_icode", n), bus.M_icode, m_exp.icode);
      check($sformatf("rnd%0d M_Cnd", n), bus.M_Cnd, m_exp.cnd);
      check($sformatf("rnd%0d M_valE", n), bus.M_valE, m_exp.valE);
      check($sformatf("rnd%0d M_valA", n), bus.M_valA, m_exp.valA);
      check($sformatf("rnd%0d M_dstE", n), bus.M_dstE, m_exp.dstE);
      check($sformatf("rnd%0d M_dstM", n), bus.M_dstM, m_exp.dstM);
      check($sformatf("rnd%0d E_icode", n), bus.E_icode, e_m.icode);
      check($sformatf("rnd%0d E_srcA", n), bus.E_srcA, e_m.srcA);
      check($sformatf("rnd%0d E_srcB", n), bus.E_srcB, e_m.srcB);
      check($sformatf("rnd%0d E_dstM", n), bus.E_dstM, e_m.dstM);
      check($sformatf("rnd%0d e_valE", n), bus.e_valE, e_exp.valE);
      check($sformatf("rnd%0d e_dstE", n), bus.e_dstE, e_exp.dstE);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage pipelined Y86-64 processor. It holds the E pipeline register fed by decode and selects ALU operands and function. It drives the existing `ALU` module, maintains the condition-code register and evaluates branch/cmov conditions. Results are registered into the M pipeline register consumed by the memory stage.

## Interface
Parameters:
- `W`, 64, datapath width (valA/valB/valC/valE)
- `RNONE`, 4'hF, "no register" ID

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `d_stat`, `d_icode`, `d_ifun`  in  3/4/4  decoded instruction status/code/function
- `d_valA`, `d_valB`, `d_valC`  in  64 each  operand values from decode
- `d_dstE`, `d_dstM`, `d_srcA`, `d_srcB`  in  4 each  register IDs
- `E_stall`  in  1  hold E register contents
- `E_bubble`  in  1  load bubble into E register (priority over `E_stall`)
- `M_bubble`  in  1  load bubble into M register
- `set_cc_block`  in  1  high when m_stat or W_stat is exceptional; suppresses CC update
- `E_srcA`, `E_srcB`, `E_dstM`, `E_icode`  out  4 each  to hazard/forwarding unit
- `e_dstE`, `e_valE`  out  4/64  combinational forwarding outputs
- `M_stat`, `M_icode`, `M_Cnd`, `M_valE`, `M_valA`, `M_dstE`, `M_dstM`  out  3/4/1/64/64/4/4  M register

## Operation
- E register, on each rising edge:
  - `E_bubble` → bubble
  - else `!E_stall` → load all `d_*` fields
  - else hold
- Bubble = icode NOP(1), ifun 0, stat AOK(1), dstE/dstM/srcA/srcB = RNONE, values 0.
- aluA select:
  - OPQ(6), RRMOVQ(2) → E_valA
  - IRMOVQ(3), RMMOVQ(4), MRMOVQ(5) → E_valC
  - CALL(8), PUSHQ(A) → −8
  - RET(9), POPQ(B) → +8
  - otherwise 0
- aluB select:
  - RMMOVQ, MRMOVQ, OPQ, CALL, PUSHQ, RET, POPQ → E_valB
  - RRMOVQ, IRMOVQ → 0
  - otherwise 0
- ALU function: `E_ifun[1:0]` when icode=OPQ, else ADD(0). Encoding: 0 add, 1 sub, 2 and, 3 xor.
- `ALU` instance: x=aluB, y=aluA, control=alufun. `e_valE` = res, i.e. aluB op aluA. `carry_bit` is unused.
- Flags from the result:
  - ZF = (valE==0)
  - SF = valE[63]
  - OF, add: aluA[63]==aluB[63] && valE[63]!=aluB[63]
  - OF, sub: aluB[63]!=aluA[63] && valE[63]!=aluB[63]
  - OF, and/xor: 0
- CC register {ZF,SF,OF}: written at the clock edge iff E_icode==OPQ && !set_cc_block. Otherwise it holds.
- e_Cnd, evaluated from the current CC register (pre-update) with E_ifun:
  - 0 → 1
  - 1 le → (SF^OF)|ZF
  - 2 l → SF^OF
  - 3 e → ZF
  - 4 ne → !ZF
  - 5 ge → !(SF^OF)
  - 6 g → !(SF^OF)&!ZF
  - 7–15 → 0
- e_Cnd applies only to JXX(7) and RRMOVQ(2); it is 1 for all other icodes.
- `e_dstE` = RNONE when icode==RRMOVQ && !e_Cnd, else E_dstE.
- M register: `M_bubble` → bubble (M_Cnd=0), else load {E_stat, E_icode, e_Cnd, e_valE, E_valA, e_dstE, E_dstM}. The M register has no stall.

## Timing
- Reset (rst_n low, async): E and M registers = bubble, CC = {ZF=1,SF=0,OF=0}. All M_* outputs show NOP/AOK/RNONE/0 immediately.
- Latency: d_* sampled at edge N, `e_valE` valid combinationally in cycle N, M_* valid after edge N+1.
- Conditions are evaluated with CC as written by an OPQ no later than the previous edge. Back-to-back OPQ then JXX uses the OPQ's flags.
- Simultaneous `E_stall` and `E_bubble`: bubble wins.
- Reset asserted mid-instruction discards E, M and CC contents without waiting for an edge.
- Arithmetic wraps modulo 2^64. OF detects signed overflow only.

## Structure
- Shared package `y86_pkg`:
  - icode constants (HALT..POPQ)
  - stat codes AOK=1, HLT=2, ADR=3, INS=4
  - ALU function codes
  - RNONE
  - bubble field values
- One sub-module: the existing `ALU`, instantiated unchanged. Operand muxes, CC and cond logic stay inline.

## Test plan
- Reset: rst_n=0 with garbage on d_* → M_icode=1, M_stat=1, M_dstE=F, CC={1,0,0}.
- OPQ sub, valA=10, valB=20 → after 2 edges M_valE=10. CC becomes {0,0,0}.
- OPQ add 0x7FFF_FFFF_FFFF_FFFF + 1 → M_valE=0x8000_0000_0000_0000, CC={0,1,1}. A following jl (ifun 2) gives M_Cnd=0. A following jle also gives M_Cnd=0.
- cmove (RRMOVQ ifun 3) with ZF=0, dstE=3 → e_dstE=F, M_Cnd=0. The same instruction with ZF=1 → M_dstE=3, M_valE=valA.
- PUSHQ with valB=0x100 → M_valE=0xF8. CALL gives the same. POPQ with valB=0xF8 → M_valE=0x100.
- Control and blocking:
  - E_stall holds E for 2 cycles, then resumes.
  - E_bubble together with E_stall → NOP.
  - OPQ xor with set_cc_block=1 → CC unchanged.
  - M_bubble → M_icode=1, M_Cnd=0.
